// File: rtl/reg_hazard_scoreboard_if.sv
// Issue / retire / stall bundle between decode, writeback and the hazard scoreboard.
// master: decode and writeback side; slave: the scoreboard itself.
interface reg_hazard_scoreboard_if;
  logic        issue_valid;
  logic [3:0]  issue_rn;
  logic [3:0]  issue_rm;
  logic [3:0]  issue_rs;
  logic        use_rn;
  logic        use_rm;
  logic        use_rs;
  logic [3:0]  issue_rd;
  logic        issue_rd_we;
  logic        issue_rd_src;
  logic        issue_wb;
  logic [3:0]  issue_cond;
  logic        issue_cpsr_we;
  logic        flush;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic        wb_rd_we;
  logic [3:0]  wb_rn;
  logic        wb_wb;
  logic        wb_cpsr_we;
  logic        stall;
  logic [15:0] busy;
  logic        flags_busy;
  logic        underflow_err;

  modport master (
    output issue_valid, issue_rn, issue_rm, issue_rs,
    output use_rn, use_rm, use_rs,
    output issue_rd, issue_rd_we, issue_rd_src, issue_wb,
    output issue_cond, issue_cpsr_we, flush,
    output wb_valid, wb_rd, wb_rd_we, wb_rn, wb_wb, wb_cpsr_we,
    input  stall, busy, flags_busy, underflow_err
  );

  modport slave (
    input  issue_valid, issue_rn, issue_rm, issue_rs,
    input  use_rn, use_rm, use_rs,
    input  issue_rd, issue_rd_we, issue_rd_src, issue_wb,
    input  issue_cond, issue_cpsr_we, flush,
    input  wb_valid, wb_rd, wb_rd_we, wb_rn, wb_wb, wb_cpsr_we,
    output stall, busy, flags_busy, underflow_err
  );
endinterface

// File: rtl/reg_hazard_scoreboard.sv
// Register/flag hazard scoreboard: counts in-flight writes per register and
// for CPSR flags, and stalls register fetch on RAW, flag or counter-full hazards.
// Ports: clk, reset (async, active-high), bus (issue/retire in, stall/busy out).
module reg_hazard_scoreboard #(
  parameter int CNT_W = 2
) (
  input logic                  clk,
  input logic                  reset,
  reg_hazard_scoreboard_if.slave bus
);

  localparam logic [CNT_W-1:0] CZERO = '0;
  localparam logic [CNT_W-1:0] CONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CMAX  = '1;
  localparam logic [3:0]       COND_AL = 4'b1110;
  localparam logic [3:0]       PC_REG  = 4'd15;

  logic [CNT_W-1:0] cnt_q [16];
  logic [CNT_W-1:0] cnt_d [16];
  logic [CNT_W-1:0] flg_q, flg_d;
  logic             err_q, err_d;

  logic [15:0] ret_dec;
  logic [15:0] wr_inc;
  logic [15:0] at_max;
  logic [15:0] eff_nz;
  logic        flg_ret;
  logic        flg_nz;
  logic        src_hz;
  logic        flg_hz;
  logic        str_hz;
  logic        stall;
  logic        accept;

  // Per-register retire/issue decode; a retire of the same register in the
  // cycle relieves the hazard because the register file is write-through.
  always_comb begin
    ret_dec = '0;
    wr_inc  = '0;
    at_max  = '0;
    eff_nz  = '0;
    for (int i = 0; i < 16; i++) begin
      ret_dec[i] = bus.wb_valid & ~bus.flush &
                   ((bus.wb_rd_we & (bus.wb_rd == 4'(i))) |
                    (bus.wb_wb & (bus.wb_rn == 4'(i))));
      wr_inc[i]  = (bus.issue_rd_we & (bus.issue_rd == 4'(i))) |
                   (bus.issue_wb & (bus.issue_rn == 4'(i)));
      at_max[i]  = (cnt_q[i] == CMAX);
      eff_nz[i]  = (cnt_q[i] != CZERO) &
                   ~((cnt_q[i] == CONE) & ret_dec[i]);
    end
  end

  assign flg_ret = bus.wb_valid & ~bus.flush & bus.wb_cpsr_we;
  assign flg_nz  = (flg_q != CZERO) & ~((flg_q == CONE) & flg_ret);

  // r15 reads come from fetch and never hazard.
  assign src_hz =
    (bus.use_rn & (bus.issue_rn != PC_REG) & eff_nz[bus.issue_rn]) |
    (bus.use_rm & (bus.issue_rm != PC_REG) & eff_nz[bus.issue_rm]) |
    (bus.use_rs & (bus.issue_rs != PC_REG) & eff_nz[bus.issue_rs]) |
    (bus.issue_rd_src & (bus.issue_rd != PC_REG) & eff_nz[bus.issue_rd]);

  assign flg_hz = (bus.issue_cond != COND_AL) & flg_nz;

  assign str_hz = (|(wr_inc & at_max & ~ret_dec)) |
                  (bus.issue_cpsr_we & (flg_q == CMAX) & ~flg_ret);

  assign stall  = ~reset & bus.issue_valid & ~bus.flush &
                  (src_hz | flg_hz | str_hz);
  assign accept = bus.issue_valid & ~stall & ~bus.flush;

  always_comb begin
    cnt_d = cnt_q;
    flg_d = flg_q;
    err_d = err_q;
    if (bus.flush) begin
      for (int i = 0; i < 16; i++) cnt_d[i] = CZERO;
      flg_d = CZERO;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (accept & wr_inc[i] & ~ret_dec[i]) begin
          cnt_d[i] = cnt_q[i] + CONE;
        end else if (~(accept & wr_inc[i]) & ret_dec[i]) begin
          if (cnt_q[i] == CZERO) err_d = 1'b1;
          else cnt_d[i] = cnt_q[i] - CONE;
        end
      end
      if (accept & bus.issue_cpsr_we & ~flg_ret) begin
        flg_d = flg_q + CONE;
      end else if (~(accept & bus.issue_cpsr_we) & flg_ret) begin
        if (flg_q == CZERO) err_d = 1'b1;
        else flg_d = flg_q - CONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) cnt_q[i] <= CZERO;
      flg_q <= CZERO;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      flg_q <= flg_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    bus.busy = '0;
    for (int i = 0; i < 16; i++) bus.busy[i] = (cnt_q[i] != CZERO);
  end

  assign bus.stall         = stall;
  assign bus.flags_busy    = (flg_q != CZERO);
  assign bus.underflow_err = err_q;

endmodule

// File: tb/tb_reg_hazard_scoreboard.sv
// Self-checking bench for reg_hazard_scoreboard.
// Expected values are queued when stimulus is driven and popped at sampling.
module tb_reg_hazard_scoreboard;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  logic [15:0] exp_q [$];
  logic [15:0] exp;

  reg_hazard_scoreboard_if bus ();

  reg_hazard_scoreboard #(.CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.issue_valid   = 1'b0;
    bus.issue_rn      = 4'd0;
    bus.issue_rm      = 4'd0;
    bus.issue_rs      = 4'd0;
    bus.use_rn        = 1'b0;
    bus.use_rm        = 1'b0;
    bus.use_rs        = 1'b0;
    bus.issue_rd      = 4'd0;
    bus.issue_rd_we   = 1'b0;
    bus.issue_rd_src  = 1'b0;
    bus.issue_wb      = 1'b0;
    bus.issue_cond    = 4'b1110;
    bus.issue_cpsr_we = 1'b0;
    bus.flush         = 1'b0;
    bus.wb_valid      = 1'b0;
    bus.wb_rd         = 4'd0;
    bus.wb_rd_we      = 1'b0;
    bus.wb_rn         = 4'd0;
    bus.wb_wb         = 1'b0;
    bus.wb_cpsr_we    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] rd);
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_rd    = rd;
    bus.issue_rd_we = 1'b1;
  endtask

  task automatic ret(input logic [3:0] rd);
    idle();
    bus.wb_valid = 1'b1;
    bus.wb_rd    = rd;
    bus.wb_rd_we = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    #2;
    exp_q.push_back(16'h0000);
    exp = exp_q.pop_front(); n_chk++;
    if (bus.busy !== exp) begin
      n_fail++; $display("FAIL rst_busy: got %h want %h", bus.busy, exp);
    end
    exp_q.push_back(16'h0000);
    exp = exp_q.pop_front(); n_chk++;
    if ({15'b0, bus.flags_busy} !== exp) begin
      n_fail++; $display("FAIL rst_flags: got %b want %h", bus.flags_busy, exp);
    end
    exp_q.push_back(16'h0000);
    exp = exp_q.pop_front(); n_chk++;
    if ({15'b0, bus.underflow_err} !== exp) begin
      n_fail++; $display("FAIL rst_err: got %b want %h", bus.underflow_err, exp);
    end
    step();
    wr(4'd2);
    bus.use_rn = 1'b1; bus.issue_rn = 4'd2;
    #1;
    exp_q.push_back(16'h0000);
    exp = exp_q.pop_front(); n_chk++;
    if ({15'b0, bus.stall} !== exp) begin
      n_fail++; $display("FAIL rst_stall: got %b want %h", bus.stall, exp);
    end
    idle();
    step();
    #2 reset = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    wr(4'd3);
    exp_q.push_back(16'h0008);
    step();
    idle();
    exp = exp_q.pop_front(); n_chk++;
    if (bus.busy !== exp) begin
      n_fail++; $display("FAIL mid_busy_set: got %h want %h", bus.busy, exp);
    end
    #2 reset = 1'b1;
    exp_q.push_back(16'h0000);
    #1;
    exp = exp_q.pop_front(); n_chk++;
    if (bus.busy !== exp) begin
      n_fail++; $display("FAIL mid_busy_clr: got %h want %h", bus.busy, exp);
    end
    #1 reset = 1'b0;
    step();
    bus.issue_valid = 1'b1; bus.use_rn = 1'b1; bus.issue_rn = 4'd3;
    exp_q.push_back(16'h0000);
    #1;
    exp = exp_q.pop_front(); n_chk++;
    if ({15'b0, bus.stall} !== exp) begin
      n_fail++; $display("FAIL mid_reader_stall: got %b want %h", bus.stall, exp);
    end
    step();
    idle();
  endtask

  task automatic test_raw();
    wr(4'd2);
    step();
    wr(4'd9);
    bus.use_rn = 1'b1; bus.issue_rn = 4'd2;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(16'h0001);
      #1;
      exp = exp_q.pop_front(); n_chk++;
      if ({15'b0, bus.stall} !== exp) begin
        n_fail++; $display("FAIL raw_stall%0d: got %b want %h", k, bus.stall, exp);
      end
      step();
    end
    bus.wb_valid = 1'b1; bus.wb_rd = 4'd2; bus.wb_rd_we = 1'b1;
    exp_q.push_back(16'h0000);
    #1;
    exp = exp_q.pop_front(); n_chk++;
    if ({15'b0, bus.stall} !== exp) begin
      n_fail++; $display("FAIL raw_release: got %b want %h", bus.stall, exp);
    end
    exp_q.push_back(16'h0200);
    step();
    idle();
    exp = exp_q.pop_front(); n_chk++;
    if (bus.busy !== exp) begin
      n_fail++; $display("FAIL raw_accepted: got %h want %h", bus.busy, exp);
    end
    ret(4'd9);
    step();
    idle();
  endtask

  task automatic test_same_cycle();
    wr(4'd5);
    step();
    wr(4'd5);
    bus.wb_valid = 1'b1; bus.wb_rd = 4'd5; bus.wb_rd_we = 1'b1;
    exp_q.push_back(16'h0000);
    #1;
    exp = exp_q.pop_front(); n_chk++;
    if ({15'b0, bus.stall} !== exp) begin
      n_fail++; $display("FAIL same_stall: got %b want %h", bus.stall, exp);
    end
    exp_q.push_back(16'h0020);
    step();
    exp = exp_q.pop_front(); n_chk++;
    if (bus.busy !== exp) begin
      n_fail++; $display("FAIL same_busy: got %h want %h", bus.busy, exp);
    end
    ret(4'd5);
    exp_q.push_back(16'h0000);
    step();
    exp = exp_q.pop_front(); n_chk++;
    if (bus.busy !== exp) begin
      n_fail++; $display("FAIL same_drain: got %h want %h", bus.busy, exp);
    end
    wr(4'd6);
    bus.issue_rn = 4'd6; bus.issue_wb = 1'b1;
    exp_q.push_back(16'h0040);
    step();
    exp = exp_q.pop_front(); n_chk++;
    if (bus.busy !== exp) begin
      n_fail++; $display("FAIL dual_busy: got %h want %h", bus.busy, exp);
    end
    ret(4'd6);
    exp_q.push_back(16'h0000);
    step();
    idle();
    exp = exp_q.pop_front(); n_chk++;
    if (bus.busy !== exp) begin
      n_fail++; $display("FAIL dual_once: got %h want %h", bus.busy, exp);
    end
    exp_q.push_back(16'h0000);
    exp = exp_q.pop_front(); n_chk++;
    if ({15'b0, bus.underflow_err} !== exp) begin
      n_fail++; $display("FAIL dual_err: got %b want %h", bus.underflow_err, exp);
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 3; k++) begin
      wr(4'd7);
      step();
    end
    wr(4'd7);
    exp_q.push_back(16'h0001);
    #1;
    exp = exp_q.pop_front(); n_chk++;
    if ({15'b0, bus.stall} !== exp) begin
      n_fail++; $display("FAIL sat_stall: got %b want %h", bus.stall, exp);
    end
    step();
    bus.wb_valid = 1'b1; bus.wb_rd = 4'd7; bus.wb_rd_we = 1'b1;
    exp_q.push_back(16'h0000);
    #1;
    exp = exp_q.pop_front(); n_chk++;
    if ({15'b0, bus.stall} !== exp) begin
      n_fail++; $display("FAIL sat_retire_stall: got %b want %h", bus.stall, exp);
    end
    step();
    for (int k = 0; k < 3; k++) begin
      ret(4'd7);
      exp_q.push_back(k < 2 ? 16'h0080 : 16'h0000);
      step();
      exp = exp_q.pop_front(); n_chk++;
      if (bus.busy !== exp) begin
        n_fail++; $display("FAIL sat_drain%0d: got %h want %h", k, bus.busy, exp);
      end
    end
    idle();
  endtask

  task automatic test_flags();
    idle();
    bus.issue_valid = 1'b1; bus.issue_cpsr_we = 1'b1;
    exp_q.push_back(16'h0001);
    step();
    exp = exp_q.pop_front(); n_chk++;
    if ({15'b0, bus.flags_busy} !== exp) begin
      n_fail++; $display("FAIL flg_busy: got %b want %h", bus.flags_busy, exp);
    end
    idle();
    bus.issue_valid = 1'b1; bus.issue_cond = 4'b0000;
    exp_q.push_back(16'h0001);
    #1;
    exp = exp_q.pop_front(); n_chk++;
    if ({15'b0, bus.stall} !== exp) begin
      n_fail++; $display("FAIL flg_cond_stall: got %b want %h", bus.stall, exp);
    end
    bus.issue_cond = 4'b1110;
    exp_q.push_back(16'h0000);
    #1;
    exp = exp_q.pop_front(); n_chk++;
    if ({15'b0, bus.stall} !== exp) begin
      n_fail++; $display("FAIL flg_al_stall: got %b want %h", bus.stall, exp);
    end
    step();
    idle();
    bus.wb_valid = 1'b1; bus.wb_cpsr_we = 1'b1;
    exp_q.push_back(16'h0000);
    step();
    idle();
    exp = exp_q.pop_front(); n_chk++;
    if ({15'b0, bus.flags_busy} !== exp) begin
      n_fail++; $display("FAIL flg_drain: got %b want %h", bus.flags_busy, exp);
    end
  endtask

  task automatic test_r15_store();
    wr(4'd15);
    step();
    wr(4'd1);
    bus.use_rn = 1'b1; bus.issue_rn = 4'd15;
    bus.use_rm = 1'b1; bus.issue_rm = 4'd15;
    exp_q.push_back(16'h0000);
    #1;
    exp = exp_q.pop_front(); n_chk++;
    if ({15'b0, bus.stall} !== exp) begin
      n_fail++; $display("FAIL r15_read_stall: got %b want %h", bus.stall, exp);
    end
    exp_q.push_back(16'h8002);
    step();
    exp = exp_q.pop_front(); n_chk++;
    if (bus.busy !== exp) begin
      n_fail++; $display("FAIL r15_busy: got %h want %h", bus.busy, exp);
    end
    idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 4'd1; bus.issue_rd_src = 1'b1;
    exp_q.push_back(16'h0001);
    #1;
    exp = exp_q.pop_front(); n_chk++;
    if ({15'b0, bus.stall} !== exp) begin
      n_fail++; $display("FAIL store_rd_stall: got %b want %h", bus.stall, exp);
    end
    idle();
    bus.wb_valid = 1'b1; bus.wb_rd = 4'd1; bus.wb_rd_we = 1'b1;
    bus.wb_rn = 4'd15; bus.wb_wb = 1'b1;
    exp_q.push_back(16'h0000);
    step();
    idle();
    exp = exp_q.pop_front(); n_chk++;
    if (bus.busy !== exp) begin
      n_fail++; $display("FAIL r15_drain: got %h want %h", bus.busy, exp);
    end
  endtask

  task automatic test_flush();
    wr(4'd4);
    exp_q.push_back(16'h0010);
    step();
    exp = exp_q.pop_front(); n_chk++;
    if (bus.busy !== exp) begin
      n_fail++; $display("FAIL fl_busy_set: got %h want %h", bus.busy, exp);
    end
    wr(4'd8);
    bus.flush = 1'b1;
    exp_q.push_back(16'h0000);
    #1;
    exp = exp_q.pop_front(); n_chk++;
    if ({15'b0, bus.stall} !== exp) begin
      n_fail++; $display("FAIL fl_stall: got %b want %h", bus.stall, exp);
    end
    exp_q.push_back(16'h0000);
    step();
    exp = exp_q.pop_front(); n_chk++;
    if (bus.busy !== exp) begin
      n_fail++; $display("FAIL fl_busy_clr: got %h want %h", bus.busy, exp);
    end
    ret(4'd4);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    step();
    idle();
    exp = exp_q.pop_front(); n_chk++;
    if (bus.busy !== exp) begin
      n_fail++; $display("FAIL fl_late_busy: got %h want %h", bus.busy, exp);
    end
    exp = exp_q.pop_front(); n_chk++;
    if ({15'b0, bus.underflow_err} !== exp) begin
      n_fail++; $display("FAIL fl_err_set: got %b want %h", bus.underflow_err, exp);
    end
    exp_q.push_back(16'h0001);
    step();
    step();
    exp = exp_q.pop_front(); n_chk++;
    if ({15'b0, bus.underflow_err} !== exp) begin
      n_fail++; $display("FAIL fl_err_sticky: got %b want %h", bus.underflow_err, exp);
    end
    #2 reset = 1'b1;
    exp_q.push_back(16'h0000);
    #1;
    exp = exp_q.pop_front(); n_chk++;
    if ({15'b0, bus.underflow_err} !== exp) begin
      n_fail++; $display("FAIL fl_err_reset: got %b want %h", bus.underflow_err, exp);
    end
    #1 reset = 1'b0;
    step();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    idle();
    test_reset();
    test_reset_mid();
    test_raw();
    test_same_cycle();
    test_saturation();
    test_flags();
    test_r15_store();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_hazard_scoreboard.md
# reg_hazard_scoreboard

Tracks destination registers and CPSR flag updates that have passed the register-fetch pipeline register but have not yet been written back. It raises a stall to the register-fetch stage when a decoding instruction reads a pending register or needs pending flags. It is the backward-direction companion of the fetch-to-execute pipeline register. Issue information enters from the decode/fetch side, retire information enters from writeback, and the stall signal returns to the fetch-stage register enables.

## Interface
- CNT_W, 2: width of each per-register in-flight counter. Maximum in-flight writes per register is 2^CNT_W - 1.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- issue_valid  in  1  an instruction is presented for issue this cycle.
- issue_rn, issue_rm, issue_rs  in  4 each  source register numbers.
- use_rn, use_rm, use_rs  in  1 each  the corresponding source is read.
- issue_rd  in  4  destination register.
- issue_rd_we  in  1  instruction writes rd (data-processing result or load).
- issue_rd_src  in  1  rd is read as a source (store data); checked against issue_rd.
- issue_wb  in  1  base writeback; rn is also written.
- issue_cond  in  4  condition field; 4'b1110 (AL) needs no flags.
- issue_cpsr_we  in  1  instruction updates CPSR flags.
- flush  in  1  pipeline squash.
- wb_valid  in  1  writeback stage retiring an instruction.
- wb_rd  in  4  retired destination.
- wb_rd_we  in  1  retired instruction wrote rd.
- wb_rn  in  4  retired base register.
- wb_wb  in  1  retired instruction wrote back rn.
- wb_cpsr_we  in  1  retired instruction updated flags.
- stall  out  1  combinational; hold fetch and the pipeline register, and insert a bubble.
- busy  out  16  registered; bit i is 1 when counter i is nonzero.
- flags_busy  out  1  registered; flag counter is nonzero.
- underflow_err  out  1  registered, sticky until reset.

## Operation
- State: 16 counters of CNT_W bits (r0–r15), one flag counter of CNT_W bits, and underflow_err.
- Effective count per register = counter minus a same-cycle retire of that register. Retire relieves the hazard in the same cycle because the register file is write-through.
- A hazard exists if any used source (rn/use_rn, rm/use_rm, rs/use_rs, rd/issue_rd_src) has an effective count of nonzero.
- A flag hazard exists if issue_cond != AL and the effective flag count is nonzero.
- A structural hazard exists if any register to be written, or the flag counter when issue_cpsr_we, is at max count and is not retiring this cycle.
- stall = issue_valid & ~flush & (hazard | flag hazard | structural hazard).
- accept = issue_valid & ~stall & ~flush.
- On accept, increment the counter of issue_rd if issue_rd_we, and the counter of issue_rn if issue_wb. If issue_rd == issue_rn with both writes set, increment once. Increment the flag counter if issue_cpsr_we.
- On wb_valid, decrement wb_rd if wb_rd_we and wb_rn if wb_wb. If wb_rd == wb_rn, decrement once. Decrement the flag counter if wb_cpsr_we.
- Increment and decrement of the same counter in one cycle leaves it unchanged.
- A decrement of a zero counter leaves it at 0 and sets underflow_err.
- flush: all counters, including flags, clear to 0 at the next edge. Retires in the flush cycle are ignored, and issue is not accepted.
- Later retires from instructions older than the flush may therefore underflow. This is saturated and flagged, with no other effect.
- Reads of r15 never hazard. The PC comes from fetch, so use_* with register 15 is masked. Writes to r15 are tracked normally.

## Timing
- Reset (asynchronous): counters = 0, busy = 16'h0000, flags_busy = 0, underflow_err = 0. stall = 0 while reset is held.
- stall has zero latency from the issue and retire inputs. busy and flags_busy reflect counters one edge after the update.
- Reset asserted mid-operation discards all pending entries immediately. The first issue after deassertion sees no hazards.
- Minimum RAW penalty: stall stays high from the cycle after the producer issues through the cycle before its retire. It drops in the retire cycle.

## Test plan
- Reset mid-operation: accept rd = 3; busy = 16'h0008. Assert reset between edges; busy = 0 immediately. After release, a reader of r3 gets stall = 0.
- RAW: accept writer rd = 2. Next cycle, reader with rn = 2 gives stall = 1 and holds while wb is idle. In the cycle with wb_valid, wb_rd = 2, wb_rd_we = 1, stall = 0 and the reader is accepted.
- Simultaneous issue and retire of r5 with count 1: count stays 1 and busy[5] stays 1. A dual write with rd = rn = 6 increments counter 6 by 1 only.
- Saturation: 3 accepted writes to r7 with CNT_W = 2. A fourth writer of r7 gives stall = 1. With a retire of r7 in the same cycle, the writer is accepted and the count stays 3.
- Flags: accept an instruction with issue_cpsr_we = 1. Next instruction with cond = 4'b0000 gives stall = 1. Same instruction with cond = 4'b1110 gives stall = 0.
- Flush then late retire: with busy = 16'h0010, assert flush; busy = 0 next edge. Then retire wb_rd = 4: counter stays 0 and underflow_err = 1 until reset.
